// File: rtl/csr_file.sv
// Machine-mode CSR file for the rv32imac core: Zicsr read/modify/write,
// 64-bit cycle/instret counters, trap-entry and mret state updates.
module csr_file #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_valid,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_op,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        instret_inc,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_epc,
  input  logic [31:0] trap_tval,
  input  logic        mret,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        irq_soft,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        irq_pending
);

  typedef enum logic [11:0] {
    MSTATUS    = 12'h300, MISA      = 12'h301, MEDELEG   = 12'h302,
    MIDELEG    = 12'h303, MIE       = 12'h304, MTVEC     = 12'h305,
    MCOUNTEREN = 12'h306, MSCRATCH  = 12'h340, MEPC      = 12'h341,
    MCAUSE     = 12'h342, MTVAL     = 12'h343, MIP       = 12'h344,
    MCYCLE     = 12'hB00, MINSTRET  = 12'hB02,
    CYCLE      = 12'hC00, TIME      = 12'hC01, INSTRET   = 12'hC02,
    CYCLEH     = 12'hC80, TIMEH     = 12'hC81, INSTRETH  = 12'hC82,
    MVENDORID  = 12'hF11, MARCHID   = 12'hF12, MIMPID    = 12'hF13,
    MHARTID    = 12'hF14
  } csr_addr_e;

  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  csr_addr_e   addr;
  logic        mstatus_mie, mstatus_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle_q, minstret_q;
  logic [31:0] mip_val, old_val, new_val;
  logic        addr_known, addr_ro, wr_en;

  assign addr    = csr_addr_e'(csr_addr);
  assign mip_val = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_soft, 3'b0};

  always_comb begin
    old_val    = '0;
    addr_known = 1'b1;
    case (addr)
      MSTATUS:                 old_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      MISA:                    old_val = 32'h4000_1105;
      MEDELEG, MIDELEG,
      MCOUNTEREN:              old_val = '0;
      MIE:                     old_val = mie_q;
      MTVEC:                   old_val = mtvec_q;
      MSCRATCH:                old_val = mscratch_q;
      MEPC:                    old_val = mepc_q;
      MCAUSE:                  old_val = mcause_q;
      MTVAL:                   old_val = mtval_q;
      MIP:                     old_val = mip_val;
      MCYCLE, CYCLE, TIME:     old_val = mcycle_q[31:0];
      CYCLEH, TIMEH:           old_val = mcycle_q[63:32];
      MINSTRET, INSTRET:       old_val = minstret_q[31:0];
      INSTRETH:                old_val = minstret_q[63:32];
      MVENDORID, MARCHID,
      MIMPID:                  old_val = '0;
      MHARTID:                 old_val = HART_ID;
      default:                 addr_known = 1'b0;
    endcase
  end

  assign addr_ro = (csr_addr[11:8] == 4'hC) || (csr_addr[11:8] == 4'hF) ||
                   (addr == MISA) || (addr == MIP);

  assign csr_illegal = csr_valid && (!addr_known || ((csr_op != 2'b00) && addr_ro));
  assign csr_rdata   = (csr_valid && !csr_illegal) ? old_val : '0;
  assign wr_en       = csr_valid && (csr_op != 2'b00) && !csr_illegal;

  always_comb begin
    new_val = old_val;
    case (csr_op)
      2'b01:   new_val = csr_wdata;
      2'b10:   new_val = old_val | csr_wdata;
      2'b11:   new_val = old_val & ~csr_wdata;
      default: new_val = old_val;
    endcase
  end

  // trap > mret > CSR write for mstatus/mepc/mcause/mtval; other registers still take the write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mtvec_q      <= MTVEC_RESET & ~32'h2;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
      mcycle_q     <= '0;
      minstret_q   <= '0;
    end else begin
      if (trap_valid) begin
        mepc_q       <= trap_epc & ~32'h1;
        mcause_q     <= trap_cause;
        mtval_q      <= trap_tval;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (wr_en) begin
        case (addr)
          MSTATUS: begin
            mstatus_mie  <= new_val[3];
            mstatus_mpie <= new_val[7];
          end
          MEPC:    mepc_q   <= new_val & ~32'h1;
          MCAUSE:  mcause_q <= new_val;
          MTVAL:   mtval_q  <= new_val;
          default: ;
        endcase
      end

      if (wr_en && addr == MIE)      mie_q      <= new_val & MIE_MASK;
      if (wr_en && addr == MTVEC)    mtvec_q    <= new_val & ~32'h2;
      if (wr_en && addr == MSCRATCH) mscratch_q <= new_val;

      // a counter write replaces the low word and suppresses that cycle's increment
      if (wr_en && addr == MCYCLE)   mcycle_q   <= {mcycle_q[63:32], new_val};
      else                           mcycle_q   <= mcycle_q + 64'd1;
      if (wr_en && addr == MINSTRET) minstret_q <= {minstret_q[63:32], new_val};
      else if (instret_inc)          minstret_q <= minstret_q + 64'd1;
    end
  end

  assign mtvec_o     = mtvec_q;
  assign mepc_o      = mepc_q;
  assign irq_pending = mstatus_mie && ((mip_val & mie_q) != '0);

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file for the rv32imac core.
- Decodes 12-bit CSR addresses from the shared CSR address enumeration and performs Zicsr read/modify/write on them.
- Holds the 64-bit cycle/instret counters and performs the trap-entry and mret state updates.
- Sits downstream of the execute-stage CSR decode; read data feeds writeback; mtvec/mepc feed the PC-select stage.

Parameters:
- HART_ID, 0, value returned by mhartid.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- csr_valid  in  1  CSR instruction executing this cycle.
- csr_addr  in  12  CSR address, using the shared enumeration values.
- csr_op  in  2  01 = write, 10 = set, 11 = clear, 00 = read-only access.
- csr_wdata  in  32  rs1 value or zero-extended uimm.
- csr_rdata  out  32  old CSR value, combinational.
- csr_illegal  out  1  access faults, combinational.
- instret_inc  in  1  one instruction retired.
- trap_valid  in  1  take trap this cycle.
- trap_cause  in  32  mcause value; bit31 = interrupt.
- trap_epc  in  32  faulting/interrupted PC.
- trap_tval  in  32  mtval value.
- mret  in  1  mret retiring.
- irq_ext, irq_timer, irq_soft  in  1 each  level interrupt inputs.
- mtvec_o  out  32  current mtvec.
- mepc_o  out  32  current mepc.
- irq_pending  out  1  (mip & mie) != 0 and mstatus.MIE = 1.

Behaviour:
Reset state:
- mstatus.MIE = 0, MPIE = 0.
- mie, mscratch, mepc, mcause, mtval, mcycle, minstret = 0.
- mtvec = MTVEC_RESET.
- csr_rdata and csr_illegal are combinational and settle to 0 when csr_valid = 0.

Read values:
- mstatus: MIE at bit 3, MPIE at bit 7, MPP[12:11] hardwired 2'b11, all other bits 0.
- misa = 32'h4000_1105 (RV32, A, C, I, M).
- mvendorid, marchid, mimpid = 0; mhartid = HART_ID.
- medeleg, mideleg, mcounteren read 0 and ignore writes.
- mip: bit 11 = irq_ext, bit 7 = irq_timer, bit 3 = irq_soft; read-only, writes ignored.
- mie: only bits 11, 7 and 3 are writable.
- mtvec: bit 1 reads 0; bit 0 is the mode bit (direct/vectored).
- mepc: bit 0 reads 0.
- cycle/cycleh and mcycle return mcycle[31:0]/[63:32]; time/timeh alias mcycle. instret/instreth and minstret alias minstret.
- fflags, frm, fcsr, and any unlisted address: csr_illegal = 1, rdata = 0.

Write rules:
- New value is computed from the old value: write = wdata; set = old | wdata; clear = old & ~wdata.
- The write commits at the next rising clk edge, only when csr_valid = 1, csr_op != 00 and csr_illegal = 0.
- csr_illegal = 1 on any write op to a read-only address: 12'hCxx, 12'hFxx, misa, mip.
- Writes to mcycle/minstret replace only the low 32 bits; there is no mcycleh/minstreth (illegal).
- Read-only op (00) to any listed address is legal.

Counters:
- mcycle increments by 1 every cycle out of reset, with 64-bit wrap.
- minstret increments when instret_inc = 1.
- A CSR write to a counter in the same cycle overrides that cycle's increment: the written value is loaded, with no +1.

Trap entry (trap_valid = 1), at the edge:
- mepc <= {trap_epc[31:1], 0}; mcause <= trap_cause; mtval <= trap_tval.
- MPIE <= MIE; MIE <= 0.

mret:
- MIE <= MPIE; MPIE <= 1.

Simultaneous events:
- Priority is trap_valid > mret > CSR write. A lower-priority update to mstatus/mepc/mcause/mtval in the same cycle is dropped.
- Counter increments still happen when a trap is taken.

Reset mid-operation:
- Asynchronous assertion immediately forces all registers to reset values.
- Deassertion is synchronized externally; no pending write survives.

Outputs:
- mtvec_o and mepc_o are registered values, visible the cycle after the write.
- irq_pending is combinational from the registers and the irq inputs.

Test Plan:
- Reset then read misa/mhartid (HART_ID=3) -> rdata 32'h4000_1105 / 3, illegal 0.
- Write mtvec 32'h8000_0103 -> readback 32'h8000_0101; mtvec_o updates the next cycle.
- Set mstatus 0x8, set mie 0x80, hold irq_timer=1 -> irq_pending=1; then clear mstatus 0x8 -> irq_pending=0.
- trap_valid with epc 32'h1003, cause 32'h8000_0007, MIE=1 -> mepc 32'h1002, mcause 32'h8000_0007, MIE=0, MPIE=1. Then mret -> MIE=1, MPIE=1.
- Write mcycle 32'hFFFF_FFFF, then idle 1 cycle -> low word 0, high word incremented by 1. Write to cycle (12'hC00) -> illegal=1 and counter not modified.
- trap_valid and CSR write to mepc in the same cycle -> mepc holds the trap value. Assert rst mid-stream -> all values return to reset in the same cycle.
